// File: rtl/receiver.sv
// ---------------------------------------------------------------------------
// receiver : asynchronous serial receiver, fixed frame format
//   start(0), 8 data bits LSB first, even parity bit, stop(1)
//
// Ports
//   Clk         in   sole clock
//   Rst_n       in   asynchronous active-low reset
//   RxD         in   serial line, idle high, asynchronous to Clk
//   RxD_data    out  last received data byte
//   RxD_ready   out  one-cycle pulse when a frame completes
//   RxD_busy    out  high while a frame is in progress
//   parity_err  out  parity status of the last completed frame
//   frame_err   out  stop-bit status of the last completed frame
//
// CLKS_PER_BIT must be an even integer >= 4.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | waiting for a 1->0 edge on the synchronized line
// START     | half a bit in; confirm start bit is still low
// DATA      | sampling 8 data bits, one per bit period
// PARITY    | sampling the parity bit
// STOP      | sampling the stop bit, publishing results
// WAIT_HIGH | stop bit was low; wait for the line to go high again
// ---------------------------------------------------------------------------
module receiver #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_ready,
    output logic       RxD_busy,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    logic          sync1_q;
    logic          rxd_s_q;
    logic          rxd_prev_q;
    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          parity_q;
    logic [7:0]    data_q;
    logic          ready_q;
    logic          busy_q;
    logic          perr_q;
    logic          ferr_q;

    logic          timer_tc;

    // Synchronizer and edge-history flops reset to the idle line level so
    // that reset release never looks like a start edge by itself.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync1_q    <= 1'b1;
            rxd_s_q    <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            sync1_q    <= RxD;
            rxd_s_q    <= sync1_q;
            rxd_prev_q <= rxd_s_q;
        end
    end

    assign timer_tc = (timer_q == '0);

    // Bit timer is a down-counter: loaded with half a bit on the start edge,
    // then with a full bit after every sample, so each sample lands on the
    // terminal count in the middle of its bit.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rxd_s_q && rxd_prev_q) begin
                        state_q <= START;
                        timer_q <= HALF_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (timer_tc) begin
                        if (!rxd_s_q) begin
                            state_q   <= DATA;
                            timer_q   <= BIT_LOAD;
                            bit_idx_q <= '0;
                        end else begin
                            // line went back high: glitch, not a start bit
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DATA: begin
                    if (timer_tc) begin
                        shift_q <= {rxd_s_q, shift_q[7:1]};
                        timer_q <= BIT_LOAD;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= PARITY;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                PARITY: begin
                    if (timer_tc) begin
                        parity_q <= rxd_s_q;
                        timer_q  <= BIT_LOAD;
                        state_q  <= STOP;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                STOP: begin
                    if (timer_tc) begin
                        data_q  <= shift_q;
                        perr_q  <= (^shift_q) != parity_q;
                        ferr_q  <= ~rxd_s_q;
                        ready_q <= 1'b1;
                        if (rxd_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= WAIT_HIGH;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // a low line here is a break, not a new start edge
                    if (rxd_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign RxD_data   = data_q;
    assign RxD_ready  = ready_q;
    assign RxD_busy   = busy_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;

endmodule
